tdm_demux4: RTL and testbench

Receive-side counterpart of the team's 4:1 selector: a time-division demultiplexer that takes a single framed stream of W-bit words and routes four consecutive words to four lane outputs a, b, c, d. The current slot is exported on s1/s2 using the selector encoding: 00→a, 01→b, 10→c, 11→d, with s1 as the MSB. All four lanes update together once a full frame has been received. The block sits at the far end of a time-multiplexed link and hands parallel lanes to downstream logic.

---
 rtl/tdm_demux4.sv | 127 ++++++++++++
 tb/tb_tdm_demux4.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// Receive-side 4:1 TDM demultiplexer: collects four framed words (slot 0 marked by sof)
// and presents them together on lanes a..d with a one-cycle frame_valid pulse.
module tdm_demux4 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         sof,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic         s1,
  output logic         s2,
  output logic         frame_valid,
  output logic         err
);

  typedef enum logic {IDLE, RECV} state_e;

  state_e       state_q, state_d;
  logic [1:0]   slot_q, slot_d;
  logic [W-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_c_q, sh_c_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic         fv_q, fv_d, err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= 2'd0;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sh_c_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sh_c_q  <= sh_c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sh_c_d  = sh_c_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        IDLE: begin
          if (sof) begin
            sh_a_d  = din;
            slot_d  = 2'd1;
            state_d = RECV;
          end
        end
        RECV: begin
          if (sof) begin
            // Early sof: drop the partial frame and restart on this word.
            err_d  = 1'b1;
            sh_a_d = din;
            slot_d = 2'd1;
          end else begin
            unique case (slot_q)
              2'd1: begin
                sh_b_d = din;
                slot_d = 2'd2;
              end
              2'd2: begin
                sh_c_d = din;
                slot_d = 2'd3;
              end
              2'd3: begin
                a_d     = sh_a_q;
                b_d     = sh_b_q;
                c_d     = sh_c_q;
                d_d     = din;
                fv_d    = 1'b1;
                slot_d  = 2'd0;
                state_d = IDLE;
              end
              default: begin
                slot_d  = 2'd0;
                state_d = IDLE;
              end
            endcase
          end
        end
        default: begin
          slot_d  = 2'd0;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign c           = c_q;
  assign d           = d_q;
  assign s1          = slot_q[1];
  assign s2          = slot_q[0];
  assign frame_valid = fv_q;
  assign err         = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (W=8): framing, stalls, garbage, early sof,
// back-to-back frames and asynchronous reset mid-frame.
module tb_tdm_demux4;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid;
  logic         sof;
  logic [W-1:0] a, b, c, d;
  logic         s1, s2, frame_valid, err;

  int checks = 0;
  int errors = 0;

  tdm_demux4 #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .a(a), .b(b), .c(c), .d(d), .s1(s1), .s2(s2),
    .frame_valid(frame_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic s, input logic [W-1:0] w);
    @(negedge clk);
    din_valid = v;
    sof       = s;
    din       = w;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [1:0] slot, input logic fv, input logic e);
    chk({tag, ".slot"}, {30'd0, s1, s2}, {30'd0, slot});
    chk({tag, ".fv"}, {31'd0, frame_valid}, {31'd0, fv});
    chk({tag, ".err"}, {31'd0, err}, {31'd0, e});
  endtask

  task automatic chk_lanes(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                           input logic [W-1:0] ec, input logic [W-1:0] ed);
    chk({tag, ".abcd"}, {a, b, c, d}, {ea, eb, ec, ed});
  endtask

  initial begin
    int fv_cnt;
    rst_n = 1'b0; din_valid = 1'b0; sof = 1'b0; din = '0;
    #23;
    chk_st("reset", 2'd0, 1'b0, 1'b0);
    chk_lanes("reset", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame with 1-bit values
    step(1, 1, 8'h0); chk_st("basic0", 2'd1, 0, 0);
    step(1, 0, 8'h1); chk_st("basic1", 2'd2, 0, 0);
    step(1, 0, 8'h0); chk_st("basic2", 2'd3, 0, 0);
    chk_lanes("basic_pre", 8'h00, 8'h00, 8'h00, 8'h00);
    step(1, 0, 8'h1); chk_st("basic3", 2'd0, 1, 0);
    chk_lanes("basic", 8'h00, 8'h01, 8'h00, 8'h01);
    step(0, 0, 8'h0); chk_st("basic_after", 2'd0, 0, 0);

    // Stalls of 3 cycles between words
    fv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, (i == 0), 8'h11 * (i + 1));
      if (frame_valid) fv_cnt++;
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          step(0, 0, 8'hEE);
          chk_st("stall_gap", 2'(i + 1), 0, 0);
          chk_lanes("stall_hold", 8'h00, 8'h01, 8'h00, 8'h01);
          if (frame_valid) fv_cnt++;
        end
      end
    end
    chk_lanes("stall", 8'h11, 8'h22, 8'h33, 8'h44);
    chk_st("stall_end", 2'd0, 1, 0);
    step(0, 0, 8'h0);
    chk("stall_fv_count", fv_cnt, 1);

    // Garbage before sof is ignored
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 8'hF0 + 8'(i));
      chk_st("garbage", 2'd0, 0, 0);
    end
    chk_lanes("garbage_hold", 8'h11, 8'h22, 8'h33, 8'h44);
    step(1, 1, 8'h1); step(1, 0, 8'h0); step(1, 0, 8'h1); step(1, 0, 8'h1);
    chk_st("garbage_frame", 2'd0, 1, 0);
    chk_lanes("garbage_frame", 8'h01, 8'h00, 8'h01, 8'h01);

    // Early sof aborts the partial frame
    step(1, 1, 8'hAA); step(1, 0, 8'hBB);
    chk_st("early_pre", 2'd2, 0, 0);
    step(1, 1, 8'h01);
    chk_st("early_sof", 2'd1, 0, 1);
    chk_lanes("early_hold", 8'h01, 8'h00, 8'h01, 8'h01);
    step(1, 0, 8'h02); chk_st("early2", 2'd2, 0, 0);
    step(1, 0, 8'h03);
    step(1, 0, 8'h04); chk_st("early_done", 2'd0, 1, 0);
    chk_lanes("early", 8'h01, 8'h02, 8'h03, 8'h04);

    // Back-to-back frames
    step(1, 1, 8'h1); chk("b2b_fv0", {31'd0, frame_valid}, 0);
    step(1, 0, 8'h1); step(1, 0, 8'h1); step(1, 0, 8'h1);
    chk_st("b2b_first", 2'd0, 1, 0);
    chk_lanes("b2b_first", 8'h01, 8'h01, 8'h01, 8'h01);
    step(1, 1, 8'h0); chk_st("b2b_second0", 2'd1, 0, 0);
    step(1, 0, 8'h1); step(1, 0, 8'h1);
    chk("b2b_gapfv", {31'd0, frame_valid}, 0);
    step(1, 0, 8'h0);
    chk_st("b2b_second", 2'd0, 1, 0);
    chk_lanes("b2b_second", 8'h00, 8'h01, 8'h01, 8'h00);

    // Asynchronous reset mid-frame, after slot 2 accepted
    step(1, 1, 8'h55); step(1, 0, 8'h66); step(1, 0, 8'h77);
    chk_st("rst_pre", 2'd3, 0, 0);
    @(negedge clk);
    din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_st("rst_async", 2'd0, 0, 0);
    chk_lanes("rst_async", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 8'h99); chk_st("rst_wait_sof", 2'd0, 0, 0);
    step(1, 1, 8'h09); step(1, 0, 8'h0A); step(1, 0, 8'h0B);
    chk_lanes("rst_partial", 8'h00, 8'h00, 8'h00, 8'h00);
    step(1, 0, 8'h0C);
    chk_st("rst_frame", 2'd0, 1, 0);
    chk_lanes("rst_frame", 8'h09, 8'h0A, 8'h0B, 8'h0C);
    step(0, 0, 8'h0);
    chk_st("final", 2'd0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
